rtc_read_sequencer: RTL and testbench
=====================================

# rtc_read_sequencer

Upstream feeder for the nine-register time/date/timer demultiplexer. On a start request it reads nine bytes from the external RTC over its multiplexed address/data bus: clock seconds, minutes and hours; date day, month and year; timer seconds, minutes and hours. It presents each byte with its register selector for exactly one cycle and holds the selector at an idle code at all other times. This is required because the demultiplexer writes on every clock edge where the selector matches an index.

## Interface
- T_PHASE, 4, clk cycles per bus phase; legal range 1..255.
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  level or pulse; begins a 9-byte read burst when idle.
- ad_in  in  8  RTC AD bus, read direction.
- ad_out  out  8  RTC AD bus, drive value.
- ad_oe  out  1  1 = drive ad_out onto the bus.
- cs_n  out  1  RTC chip select, active-low.
- wr_n  out  1  RTC write strobe, active-low; latches the address.
- rd_n  out  1  RTC read strobe, active-low.
- a_d  out  1  1 = address phase, 0 = data phase.
- dato  out  8  byte read from the RTC, valid while selector != 4'hF.
- selector  out  4  demux index 0..8, or 4'hF when idle.
- busy  out  1  high from the first ADDR cycle through the last GAP cycle.
- done  out  1  one-cycle pulse after the ninth byte.

## Operation
- Fixed address table, index -> RTC address:
  - 0 -> 0x21, 1 -> 0x22, 2 -> 0x23 (clock s/m/h)
  - 3 -> 0x24, 4 -> 0x25, 5 -> 0x26 (day, month, year)
  - 6 -> 0x41, 7 -> 0x42, 8 -> 0x43 (timer s/m/h)
- FSM states: IDLE, ADDR, AHOLD, DATA, PUB, GAP.
- IDLE: start=1 clears idx to 0 and goes to ADDR. start during any other state is ignored; no queuing.
- ADDR (T_PHASE cycles): cs_n=0, a_d=1, wr_n=0, ad_oe=1, ad_out=addr[idx].
- AHOLD (T_PHASE cycles): wr_n=1. cs_n, a_d, ad_oe and ad_out are held.
- DATA (T_PHASE cycles): a_d=0, ad_oe=0, rd_n=0, cs_n=0. ad_in is captured into the data register on the last DATA cycle.
- PUB (1 cycle): selector=idx, dato=captured byte, rd_n=1, cs_n=0.
- GAP (T_PHASE cycles): cs_n=1, all strobes high, selector=4'hF.
  - idx<8: increment idx, go to ADDR.
  - idx==8: go to IDLE and assert done for the first IDLE cycle.
- dato holds its last published value between PUB cycles.
- A phase counter runs from 0 to T_PHASE-1 and is reloaded on every state change.
- Idle bus state (IDLE and GAP): cs_n=wr_n=rd_n=1, a_d=1, ad_oe=0.

## Timing
- Reset values: state IDLE, idx 0, selector 4'hF, dato 8'h00, ad_out 8'h00, ad_oe 0, cs_n/wr_n/rd_n 1, a_d 1, busy 0, done 0.
- start is sampled at edge N; ADDR outputs are visible in cycle N+1.
- Per byte: 4*T_PHASE+1 cycles.
- Burst length: 9*(4*T_PHASE+1) cycles; done follows in the next cycle.
- PUB for byte k occurs (k+1)*(4*T_PHASE+1) - T_PHASE cycles after start is accepted.
- selector is never 0..8 outside PUB; at most one demux write per byte.
- reset asserted mid-burst: all outputs return to reset values at the next edge, with no PUB or done emitted. This holds even when reset coincides with PUB.
- start asserted on the same edge as done: accepted, and a new burst starts immediately.
- T_PHASE=1: every phase is one cycle; the sequence is unchanged.

## Structure
- Shared package rtc_pkg holds:
  - RTC address constants and the idx->addr table.
  - Selector index constants SEL_SEG_R..SEL_HOR_T (0..8) and SEL_IDLE = 4'hF.
  - The state enum.
- One sub-module, rtc_phase_timer: loadable down-counter parameterized by T_PHASE, outputs a last-cycle flag. The FSM, idx counter and data register stay in the top.

## Test plan
- Reset then idle: selector stays 4'hF, cs_n=1, ad_oe=0 for 50 cycles with start=0.
- T_PHASE=2, start pulse, RTC model returns addr^8'hFF: selector 0..8 each high for exactly 1 cycle, 9 cycles apart. dato sequence is DE, DD, DC, DB, DA, D9, BE, BD, BC. done appears once, 82 cycles after start.
- Bus protocol check: in every byte, wr_n is low only while a_d=1 and ad_oe=1, and rd_n is low only while a_d=0 and ad_oe=0. ad_out matches 0x21..0x26 then 0x41..0x43.
- start held high continuously: back-to-back bursts, the second beginning the cycle after done, and no idle selector glitch to an index.
- reset asserted during byte 4 DATA: next cycle all outputs are at reset values. A subsequent start restarts at idx 0 with address 0x21.
- T_PHASE=1: byte period is 5 cycles and the full burst is 45 cycles.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC read path: bus addresses, demux selector
// codes and the read sequencer state encoding.
package rtc_pkg;

    // RTC register addresses on the multiplexed AD bus
    localparam logic [7:0] RTC_ADDR_SEG_R = 8'h21;
    localparam logic [7:0] RTC_ADDR_MIN_R = 8'h22;
    localparam logic [7:0] RTC_ADDR_HOR_R = 8'h23;
    localparam logic [7:0] RTC_ADDR_DAY   = 8'h24;
    localparam logic [7:0] RTC_ADDR_MON   = 8'h25;
    localparam logic [7:0] RTC_ADDR_YEA   = 8'h26;
    localparam logic [7:0] RTC_ADDR_SEG_T = 8'h41;
    localparam logic [7:0] RTC_ADDR_MIN_T = 8'h42;
    localparam logic [7:0] RTC_ADDR_HOR_T = 8'h43;

    // Demux selector indices; SEL_IDLE never matches a demux register
    localparam logic [3:0] SEL_SEG_R = 4'd0;
    localparam logic [3:0] SEL_MIN_R = 4'd1;
    localparam logic [3:0] SEL_HOR_R = 4'd2;
    localparam logic [3:0] SEL_DAY   = 4'd3;
    localparam logic [3:0] SEL_MON   = 4'd4;
    localparam logic [3:0] SEL_YEA   = 4'd5;
    localparam logic [3:0] SEL_SEG_T = 4'd6;
    localparam logic [3:0] SEL_MIN_T = 4'd7;
    localparam logic [3:0] SEL_HOR_T = 4'd8;
    localparam logic [3:0] SEL_IDLE  = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_AHOLD = 3'd2,
        ST_DATA  = 3'd3,
        ST_PUB   = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    // Selector index -> RTC address lookup
    function automatic logic [7:0] rtc_addr(input logic [3:0] idx);
        logic [7:0] a;
        case (idx)
            SEL_SEG_R: a = RTC_ADDR_SEG_R;
            SEL_MIN_R: a = RTC_ADDR_MIN_R;
            SEL_HOR_R: a = RTC_ADDR_HOR_R;
            SEL_DAY:   a = RTC_ADDR_DAY;
            SEL_MON:   a = RTC_ADDR_MON;
            SEL_YEA:   a = RTC_ADDR_YEA;
            SEL_SEG_T: a = RTC_ADDR_SEG_T;
            SEL_MIN_T: a = RTC_ADDR_MIN_T;
            SEL_HOR_T: a = RTC_ADDR_HOR_T;
            default:   a = 8'h00;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Bus phase timer: reloads to T_PHASE-1 on every state change and counts
// down; last is high in the final cycle of the phase.
module rtc_phase_timer #(
    parameter int T_PHASE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic last
);

    localparam logic [7:0] LOAD_VAL = 8'(T_PHASE - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Reload on phase entry, otherwise count down and stop at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == 8'd0);

endmodule

// File: rtl/rtc_read_sequencer.sv
// Reads the nine time/date/timer bytes from the RTC over its multiplexed
// AD bus and publishes each one to the demux for exactly one cycle.
module rtc_read_sequencer
    import rtc_pkg::*;
#(
    parameter int T_PHASE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       a_d,
    output logic [7:0] dato,
    output logic [3:0] selector,
    output logic       busy,
    output logic       done
);

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] dato_q, dato_d;
    logic [7:0] ad_out_q, ad_out_d;
    logic [3:0] selector_q, selector_d;
    logic       ad_oe_q, ad_oe_d;
    logic       cs_n_q, cs_n_d;
    logic       wr_n_q, wr_n_d;
    logic       rd_n_q, rd_n_d;
    logic       a_d_q, a_d_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic phase_load;
    logic phase_last;

    assign phase_load = (state_d != state_q);

    rtc_phase_timer #(
        .T_PHASE(T_PHASE)
    ) u_phase_timer (
        .clk  (clk),
        .reset(reset),
        .load (phase_load),
        .last (phase_last)
    );

    // Next state, byte index, captured data and the outputs for the next
    // cycle, decoded from the next state so every output is registered
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        dato_d     = dato_q;
        ad_out_d   = ad_out_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d   = SEL_SEG_R;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (phase_last) state_d = ST_AHOLD;
            end
            ST_AHOLD: begin
                if (phase_last) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (phase_last) begin
                    dato_d  = ad_in;
                    state_d = ST_PUB;
                end
            end
            ST_PUB: begin
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (phase_last) begin
                    if (idx_q == SEL_HOR_T) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = 4'(idx_q + 4'd1);
                        state_d = ST_ADDR;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Idle bus unless the next state drives something
        cs_n_d     = 1'b1;
        wr_n_d     = 1'b1;
        rd_n_d     = 1'b1;
        a_d_d      = 1'b1;
        ad_oe_d    = 1'b0;
        selector_d = SEL_IDLE;

        case (state_d)
            ST_ADDR: begin
                cs_n_d   = 1'b0;
                wr_n_d   = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = rtc_addr(idx_d);
            end
            ST_AHOLD: begin
                cs_n_d  = 1'b0;
                ad_oe_d = 1'b1;
            end
            ST_DATA: begin
                cs_n_d = 1'b0;
                a_d_d  = 1'b0;
                rd_n_d = 1'b0;
            end
            ST_PUB: begin
                cs_n_d     = 1'b0;
                a_d_d      = 1'b0;
                selector_d = idx_d;
            end
            default: begin
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // FSM and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= 4'd0;
            dato_q     <= 8'h00;
            ad_out_q   <= 8'h00;
            selector_q <= SEL_IDLE;
            ad_oe_q    <= 1'b0;
            cs_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            a_d_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            dato_q     <= dato_d;
            ad_out_q   <= ad_out_d;
            selector_q <= selector_d;
            ad_oe_q    <= ad_oe_d;
            cs_n_q     <= cs_n_d;
            wr_n_q     <= wr_n_d;
            rd_n_q     <= rd_n_d;
            a_d_q      <= a_d_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign ad_out   = ad_out_q;
    assign ad_oe    = ad_oe_q;
    assign cs_n     = cs_n_q;
    assign wr_n     = wr_n_q;
    assign rd_n     = rd_n_q;
    assign a_d      = a_d_q;
    assign dato     = dato_q;
    assign selector = selector_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// Directed bench for rtc_read_sequencer: one instance at T_PHASE=2 and one
// at T_PHASE=1, each talking to a tiny RTC model that answers addr^8'hFF.
module tb_rtc_read_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset  = 1'b1;
    logic start1 = 1'b0;
    logic start2 = 1'b0;

    logic [7:0] ad_in2, ad_out2, dato2;
    logic       ad_oe2, cs_n2, wr_n2, rd_n2, a_d2, busy2, done2;
    logic [3:0] selector2;
    logic [7:0] ad_in1, ad_out1, dato1;
    logic       ad_oe1, cs_n1, wr_n1, rd_n1, a_d1, busy1, done1;
    logic [3:0] selector1;

    rtc_read_sequencer #(.T_PHASE(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .ad_in(ad_in2),
        .ad_out(ad_out2), .ad_oe(ad_oe2), .cs_n(cs_n2), .wr_n(wr_n2),
        .rd_n(rd_n2), .a_d(a_d2), .dato(dato2), .selector(selector2),
        .busy(busy2), .done(done2)
    );

    rtc_read_sequencer #(.T_PHASE(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .ad_in(ad_in1),
        .ad_out(ad_out1), .ad_oe(ad_oe1), .cs_n(cs_n1), .wr_n(wr_n1),
        .rd_n(rd_n1), .a_d(a_d1), .dato(dato1), .selector(selector1),
        .busy(busy1), .done(done1)
    );

    // RTC models: latch the address on the write strobe, answer its inverse
    logic [7:0] lat2 = 8'h00;
    logic [7:0] lat1 = 8'h00;
    always @(posedge clk) begin
        if (!wr_n2) lat2 <= ad_out2;
        if (!wr_n1) lat1 <= ad_out1;
    end
    assign ad_in2 = lat2 ^ 8'hFF;
    assign ad_in1 = lat1 ^ 8'hFF;

    // Monitor mux: use1 selects which instance the capture task watches
    logic       use1 = 1'b0;
    logic [3:0] m_sel;
    logic [7:0] m_dato, m_aout;
    logic       m_done, m_busy, m_wr, m_rd, m_ad, m_oe;
    assign m_sel  = use1 ? selector1 : selector2;
    assign m_dato = use1 ? dato1 : dato2;
    assign m_aout = use1 ? ad_out1 : ad_out2;
    assign m_done = use1 ? done1 : done2;
    assign m_busy = use1 ? busy1 : busy2;
    assign m_wr   = use1 ? wr_n1 : wr_n2;
    assign m_rd   = use1 ? rd_n1 : rd_n2;
    assign m_ad   = use1 ? a_d1 : a_d2;
    assign m_oe   = use1 ? ad_oe1 : ad_oe2;

    int n_chk  = 0;
    int n_pass = 0;

    int         ev_cyc [32];
    logic [3:0] ev_sel [32];
    logic [7:0] ev_dat [32];
    logic [7:0] addr_seq [32];
    int         done_cyc [4];
    int n_ev, n_addr, done_n, busy_n, proto_err, bad_sel;

    logic [7:0] exp_addr [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    logic [7:0] exp_dato [9] = '{8'hDE, 8'hDD, 8'hDC, 8'hDB, 8'hDA, 8'hD9, 8'hBE, 8'hBD, 8'hBC};

    localparam logic [26:0] RESET_VEC = {4'hF, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp);
        $display("check %-18s observed 'h%0h required 'h%0h", tag, obs, exp);
    endtask

    function automatic logic [26:0] out_vec2();
        return {selector2, dato2, ad_out2, ad_oe2, cs_n2, wr_n2, rd_n2, a_d2, busy2, done2};
    endfunction

    // Sample ncyc cycles on falling edges; cycle 1 is the first after the accept edge
    task automatic run_capture(input int ncyc, input int drop_at);
        logic prev_wr;
        prev_wr = 1'b1;
        n_ev = 0; n_addr = 0; done_n = 0; busy_n = 0; proto_err = 0; bad_sel = 0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (m_sel != 4'hF) begin
                if (m_sel > 4'd8) bad_sel++;
                if (n_ev < 32) begin
                    ev_cyc[n_ev] = c;
                    ev_sel[n_ev] = m_sel;
                    ev_dat[n_ev] = m_dato;
                end
                n_ev++;
            end
            if (m_done) begin
                if (done_n < 4) done_cyc[done_n] = c;
                done_n++;
            end
            if (m_busy) busy_n++;
            if (!m_wr && !(m_ad && m_oe)) proto_err++;
            if (!m_rd && !(!m_ad && !m_oe)) proto_err++;
            if (!m_wr && prev_wr) begin
                if (n_addr < 32) addr_seq[n_addr] = m_aout;
                n_addr++;
            end
            prev_wr = m_wr;
            if (c == drop_at) begin
                start1 = 1'b0;
                start2 = 1'b0;
            end
        end
    endtask

    // Single-cycle start pulse, accepted at the next rising edge
    task automatic pulse_start(input logic on1);
        @(negedge clk);
        if (on1) start1 = 1'b1; else start2 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int idle_bad;

        // Reset then 50 idle cycles
        do_reset(3);
        check("reset_vals", 32'(out_vec2()), 32'(RESET_VEC));
        idle_bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (selector2 != 4'hF || cs_n2 != 1'b1 || ad_oe2 != 1'b0) idle_bad++;
        end
        check("idle_50", 32'(idle_bad), 32'd0);

        // T_PHASE=2 single burst
        use1 = 1'b0;
        pulse_start(1'b0);
        run_capture(90, 0);
        check("t2_events", 32'(n_ev), 32'd9);
        check("t2_done_cnt", 32'(done_n), 32'd1);
        check("t2_done_cyc", 32'(done_cyc[0]), 32'd82);
        check("t2_busy_cyc", 32'(busy_n), 32'd81);
        check("t2_protocol", 32'(proto_err), 32'd0);
        check("t2_addr_cnt", 32'(n_addr), 32'd9);
        for (int k = 0; k < 9; k++) begin
            check($sformatf("t2_sel%0d", k), 32'(ev_sel[k]), 32'(k));
            check($sformatf("t2_cyc%0d", k), 32'(ev_cyc[k]), 32'(9 * k + 7));
            check($sformatf("t2_dato%0d", k), 32'(ev_dat[k]), 32'(exp_dato[k]));
            check($sformatf("t2_addr%0d", k), 32'(addr_seq[k]), 32'(exp_addr[k]));
        end
        check("t2_dato_hold", 32'(dato2), 32'h0BC);

        // start held high: two back-to-back bursts
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        run_capture(164, 164);
        check("held_events", 32'(n_ev), 32'd18);
        check("held_done_cnt", 32'(done_n), 32'd2);
        check("held_done1", 32'(done_cyc[0]), 32'd82);
        check("held_done2", 32'(done_cyc[1]), 32'd164);
        check("held_b2_cyc0", 32'(ev_cyc[9]), 32'd89);
        check("held_b2_sel0", 32'(ev_sel[9]), 32'd0);
        check("held_b2_cyc8", 32'(ev_cyc[17]), 32'd161);
        check("held_b2_dat0", 32'(ev_dat[9]), 32'h0DE);
        check("held_bad_sel", 32'(bad_sel), 32'd0);
        repeat (5) @(negedge clk);
        check("held_idle_after", 32'(busy2), 32'd0);

        // Reset during DATA of byte 4 (cycles 41..42)
        pulse_start(1'b0);
        run_capture(40, 0);
        @(negedge clk);
        check("b4_in_data", 32'({rd_n2, a_d2, selector2}), 32'({1'b0, 1'b0, 4'hF}));
        reset = 1'b1;
        @(negedge clk);
        check("mid_reset_vals", 32'(out_vec2()), 32'(RESET_VEC));
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_reset_idle", 32'({selector2, busy2, done2}), 32'({4'hF, 1'b0, 1'b0}));
        pulse_start(1'b0);
        run_capture(10, 0);
        check("restart_addr", 32'(addr_seq[0]), 32'h021);
        check("restart_sel", 32'(ev_sel[0]), 32'd0);
        check("restart_cyc", 32'(ev_cyc[0]), 32'd7);
        do_reset(2);

        // T_PHASE=1 burst
        use1 = 1'b1;
        pulse_start(1'b1);
        run_capture(50, 0);
        check("t1_events", 32'(n_ev), 32'd9);
        check("t1_cyc0", 32'(ev_cyc[0]), 32'd4);
        check("t1_cyc1", 32'(ev_cyc[1]), 32'd9);
        check("t1_cyc8", 32'(ev_cyc[8]), 32'd44);
        check("t1_done_cyc", 32'(done_cyc[0]), 32'd46);
        check("t1_busy_cyc", 32'(busy_n), 32'd45);
        check("t1_dato0", 32'(ev_dat[0]), 32'h0DE);
        check("t1_dato8", 32'(ev_dat[8]), 32'h0BC);
        check("t1_addr6", 32'(addr_seq[6]), 32'h041);
        check("t1_protocol", 32'(proto_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
